// File: rtl/wb_port_scheduler_pkg.sv
// Shared types for the register-file write-port scheduler.
// Holds the register address width, the x0 constant and the starvation FSM encoding.
package wb_port_scheduler_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } sched_state_t;

endpackage

// File: rtl/wb_port_scheduler_if.sv
// Bundle of writeback, LLU, issue, decode and reg_file signals around the write-port scheduler.
// The master side is the surrounding pipeline; the slave side is the scheduler.
interface wb_port_scheduler_if #(
  parameter int DATA_WIDTH = 32
);
  import wb_port_scheduler_pkg::*;

  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic                  issue_ready;
  logic                  llu_valid;
  logic [REG_ADDR_W-1:0] llu_rd;
  logic [DATA_WIDTH-1:0] llu_data;
  logic                  llu_ready;
  logic [REG_ADDR_W-1:0] dec_rs1;
  logic [REG_ADDR_W-1:0] dec_rs2;
  logic [REG_ADDR_W-1:0] dec_rd;
  logic                  dec_stall;
  logic                  pipe_hold;
  logic                  proto_err;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_a3;
  logic [DATA_WIDTH-1:0] rf_wd3;

  modport master (
    output wb_en, wb_rd, wb_data, issue_valid, issue_rd, llu_valid, llu_rd, llu_data,
           dec_rs1, dec_rs2, dec_rd,
    input  issue_ready, llu_ready, dec_stall, pipe_hold, proto_err, rf_we, rf_a3, rf_wd3
  );

  modport slave (
    input  wb_en, wb_rd, wb_data, issue_valid, issue_rd, llu_valid, llu_rd, llu_data,
           dec_rs1, dec_rs2, dec_rd,
    output issue_ready, llu_ready, dec_stall, pipe_hold, proto_err, rf_we, rf_a3, rf_wd3
  );

endinterface

// File: rtl/wb_port_scheduler_scoreboard.sv
// Busy scoreboard of LLU destinations: set on honoured issue, cleared on LLU transfer, set wins.
// Reads are combinational; issue is back-pressured while its destination is already busy.
module wb_scoreboard
  import wb_port_scheduler_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  input  logic [REG_ADDR_W-1:0] rd_a,
  input  logic [REG_ADDR_W-1:0] rd_b,
  input  logic [REG_ADDR_W-1:0] rd_c,
  output logic                  hit
);

  logic [NUM_REGS-1:0] busy;
  logic                set_en;

  assign issue_ready = !busy[issue_rd];
  assign set_en      = issue_valid && issue_ready && (issue_rd != X0);
  assign hit         = busy[rd_a] | busy[rd_b] | busy[rd_c];

  // Set is applied after clear so a same-register collision leaves the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_rd] <= 1'b0;
      if (set_en) busy[issue_rd] <= 1'b1;
    end
  end

endmodule

// File: rtl/wb_port_scheduler.sv
// Arbitrates the single reg_file write port: pipeline writeback first, LLU otherwise (0-cycle grant).
// A blocked LLU is counted; after STARVE_LIMIT blocked cycles pipe_hold asks for a writeback bubble.
module wb_port_scheduler
  import wb_port_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGS     = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  wb_port_scheduler_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  sched_state_t          state, state_nxt;
  logic [CNT_W-1:0]      starve_cnt, cnt_nxt, cnt_inc;
  logic                  llu_ready_c, llu_xfer;
  logic                  rf_we_c;
  logic [REG_ADDR_W-1:0] a3_c;
  logic [DATA_WIDTH-1:0] wd3_c;
  logic                  pipe_hold_q, proto_err_q;

  always_comb begin
    llu_ready_c = 1'b0;
    rf_we_c     = 1'b0;
    a3_c        = '0;
    wd3_c       = '0;
    if (!rst) begin
      if (bus.wb_en) begin
        a3_c    = bus.wb_rd;
        wd3_c   = bus.wb_data;
        rf_we_c = (bus.wb_rd != X0);
      end else if (bus.llu_valid) begin
        llu_ready_c = 1'b1;
        a3_c        = bus.llu_rd;
        wd3_c       = bus.llu_data;
        rf_we_c     = (bus.llu_rd != X0);
      end
    end
  end

  assign llu_xfer = bus.llu_valid && llu_ready_c;
  assign cnt_inc  = starve_cnt + CNT_W'(1);

  // Counter saturates at LIMIT while holding; only a transfer or a dropped request releases it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = starve_cnt;
    if (!bus.llu_valid || llu_xfer) begin
      state_nxt = ARB;
      cnt_nxt   = '0;
    end else if (state != HOLD) begin
      cnt_nxt   = cnt_inc;
      state_nxt = (cnt_inc >= LIMIT) ? HOLD : WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARB;
      starve_cnt  <= '0;
      pipe_hold_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      starve_cnt  <= cnt_nxt;
      pipe_hold_q <= (state_nxt == HOLD);
      proto_err_q <= proto_err_q | (bus.wb_en & pipe_hold_q);
    end
  end

  wb_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (bus.issue_valid),
    .issue_rd    (bus.issue_rd),
    .issue_ready (bus.issue_ready),
    .clr_en      (llu_xfer),
    .clr_rd      (bus.llu_rd),
    .rd_a        (bus.dec_rs1),
    .rd_b        (bus.dec_rs2),
    .rd_c        (bus.dec_rd),
    .hit         (bus.dec_stall)
  );

  assign bus.llu_ready = llu_ready_c;
  assign bus.rf_we     = rf_we_c;
  assign bus.rf_a3     = a3_c;
  assign bus.rf_wd3    = wd3_c;
  assign bus.pipe_hold = pipe_hold_q;
  assign bus.proto_err = proto_err_q;

endmodule
